truth_table_sampler: RTL and testbench
======================================

Name: truth_table_sampler

Overview:
- Exhaustive stimulus driver and response collector that sits directly upstream and downstream of a generated combinational netlist block.
- Such a block has N_IN primary inputs x0..x(N_IN-1) and N_OUT outputs f1..fN_OUT.
- On a start request it drives every input vector 0..2^N_IN-1 into the netlist, samples the outputs, and packs them into a truth-table word.
- The word, plus a per-output ones count, is delivered over a valid/ready handshake to the dataset labelling / equivalence-check logic.

Parameters:
- N_IN, 4, number of netlist primary inputs (1..8).
- N_OUT, 1, number of netlist outputs (1..4).
- SETTLE, 1, extra cycles each vector is held before sampling (0..15); covers the netlist's combinational depth.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse or level; accepted only in IDLE.
- busy  out  1  high from accept until tt_valid handshake completes.
- vec_o  out  N_IN  drives netlist inputs; vec_o[0]=x0, vec_o[N_IN-1]=x(N_IN-1).
- f_i  in  N_OUT  netlist outputs; f_i[0]=f1.
- tt_valid  out  1  result available.
- tt_ready  in  1  consumer accepts result.
- tt_data  out  N_OUT*2^N_IN  truth tables; output k occupies bits [k*2^N_IN +: 2^N_IN]; bit v = response to vector v.
- ones_cnt  out  N_OUT*(N_IN+1)  per-output count of 1s, same lane order.

Behaviour:
- Reset (async assert, sync release): state=IDLE; vec_o=0, busy=0, tt_valid=0, tt_data=0, ones_cnt=0; settle counter=0.
- FSM states:
  - IDLE: on start=1, go to HOLD. vec_o=0, settle counter=0, tt_data and ones_cnt cleared, busy=1 from the next cycle.
  - HOLD: vec_o is stable. Settle counter increments each cycle. When it reaches SETTLE, go to SAMPLE. With SETTLE=0, HOLD lasts one cycle.
  - SAMPLE: one cycle. f_i captured into bit vec_o of every lane; ones_cnt lanes += f_i[k]. If vec_o == 2^N_IN-1, go to DONE; otherwise vec_o += 1, counter=0, go to HOLD.
  - DONE: tt_valid=1; tt_data and ones_cnt held stable. On tt_valid&&tt_ready, tt_valid=0, busy=0, go to IDLE. vec_o keeps its last value until the next start.
- Each vector is driven for exactly SETTLE+2 cycles (HOLD×(SETTLE+1) + SAMPLE).
- Latency: start accepted at edge 0 → tt_valid high after edge 2^N_IN*(SETTLE+2). Example: N_IN=4, SETTLE=1 → edge 48.
- Widths and wrap-around: the vector counter is N_IN+1 bits internally, so the terminal compare never wraps silently. ones_cnt saturates naturally at 2^N_IN (fits in N_IN+1 bits).
- start while busy: ignored; no restart, no queueing.
- tt_ready high before tt_valid: no effect. tt_valid stays high until the handshake; the consumer may stall indefinitely.
- start in the same cycle as the DONE handshake: ignored. A new run needs start in IDLE.
- rst_n low mid-run: immediate return to reset values; partial truth table discarded.
- f_i is sampled only in SAMPLE; glitches during HOLD are ignored.

Decomposition:
- Shared package truth_table_pkg:
  - state enum {IDLE, HOLD, SAMPLE, DONE};
  - function tt_width(n_in, n_out);
  - localparams for max N_IN/N_OUT.
- One sub-module, tt_lane_accum: per-output bit-insert + ones counter, instantiated N_OUT times by generate. The FSM and vector counter stay in the top.

Test Plan:
- Loopback f_i = x1 XNOR x3, N_IN=4, N_OUT=1, SETTLE=1 → tt_data=16'hCC33, ones_cnt=8, tt_valid at edge 48 after start.
- f_i tied 0, then tied 1 → tt_data=16'h0000/ones_cnt=0, then 16'hFFFF/ones_cnt=16 (5-bit full-scale).
- Backpressure: tt_ready=0 for 20 cycles after tt_valid → tt_valid, tt_data, busy stable; start pulses ignored; completes on the first tt_ready=1 cycle.
- N_OUT=2, f_i = {x0 AND x1, x2 OR x3}:
  - lane0=16'hFFF0 (OR of x2,x3), ones=12;
  - lane1=16'h8888 (AND of x0,x1), ones=4.
- rst_n asserted while vec_o=7 → all outputs 0 asynchronously. A new start after release yields a correct full table (XNOR case 16'hCC33).
- SETTLE=0 and SETTLE=15 with the XNOR loopback → same 16'hCC33. tt_valid at edges 32 and 272 respectively; vec_o changes only every SETTLE+2 cycles.

Source files
------------

// File: rtl/truth_table_pkg.sv
// Shared types and helpers for the truth-table sampler slice.
package truth_table_pkg;

  localparam int unsigned MAX_N_IN  = 8;
  localparam int unsigned MAX_N_OUT = 4;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SAMPLE,
    DONE
  } tts_state_e;

  // Total packed truth-table width: one 2^n_in-bit table per output.
  function automatic int unsigned tt_width(input int unsigned n_in, input int unsigned n_out);
    return n_out << n_in;
  endfunction

endpackage

// File: rtl/tt_lane_accum.sv
// One output lane: inserts the sampled response at the current vector's bit
// position and keeps a running count of ones.
module tt_lane_accum
  import truth_table_pkg::*;
#(
  parameter int unsigned N_IN = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     smp,
  input  logic [N_IN-1:0]          vec,
  input  logic                     f,
  output logic [(1 << N_IN)-1:0]   tt,
  output logic [N_IN:0]            ones
);

  localparam int unsigned CW = N_IN + 1;

  // Clear at run start, capture one response bit per SAMPLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt   <= '0;
      ones <= '0;
    end else if (clr) begin
      tt   <= '0;
      ones <= '0;
    end else if (smp) begin
      tt[vec] <= f;
      ones    <= ones + CW'(f);
    end
  end

endmodule

// File: rtl/truth_table_sampler.sv
// Exhaustive stimulus driver / response collector for a combinational netlist.
// Walks every input vector, holds each for SETTLE+1 cycles, samples once, and
// hands the packed truth tables plus ones counts over a valid/ready handshake.
module truth_table_sampler
  import truth_table_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_OUT  = 1,
  parameter int unsigned SETTLE = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic [N_IN-1:0]                 vec_o,
  input  logic [N_OUT-1:0]                f_i,
  output logic                            tt_valid,
  input  logic                            tt_ready,
  output logic [tt_width(N_IN, N_OUT)-1:0] tt_data,
  output logic [N_OUT*(N_IN+1)-1:0]       ones_cnt
);

  localparam int unsigned DEPTH = 1 << N_IN;
  localparam int unsigned CW    = N_IN + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam logic [3:0]    SETTLE_MAX = 4'(SETTLE);

  tts_state_e    state, state_nx;
  logic [CW-1:0] vec_cnt;
  logic [3:0]    settle_cnt;
  logic          clr;
  logic          smp;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and lane control decode.
  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    smp      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clr      = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (settle_cnt == SETTLE_MAX) state_nx = SAMPLE;
      end
      SAMPLE: begin
        smp = 1'b1;
        if (vec_cnt == LAST) state_nx = DONE;
        else                 state_nx = HOLD;
      end
      DONE: begin
        if (tt_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Vector and settle counters; the extra vector bit keeps the terminal
  // compare exact, and vec_o holds its last value after DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            vec_cnt    <= '0;
            settle_cnt <= '0;
          end
        end
        HOLD: begin
          if (settle_cnt != SETTLE_MAX) settle_cnt <= settle_cnt + 4'd1;
        end
        SAMPLE: begin
          if (vec_cnt != LAST) begin
            vec_cnt    <= vec_cnt + CW'(1);
            settle_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign vec_o    = vec_cnt[N_IN-1:0];
  assign busy     = (state != IDLE);
  assign tt_valid = (state == DONE);

  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    tt_lane_accum #(.N_IN(N_IN)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .smp  (smp),
      .vec  (vec_o),
      .f    (f_i[k]),
      .tt   (tt_data[k*DEPTH +: DEPTH]),
      .ones (ones_cnt[k*CW +: CW])
    );
  end

endmodule

// File: tb/tb_truth_table_sampler.sv
// Scoreboard bench for truth_table_sampler: four instances covering SETTLE
// 1/0/15 with one output and SETTLE 1 with two outputs.
module tb_truth_table_sampler;

  typedef struct {
    logic [31:0] tt;
    logic [15:0] ones;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start [4];
  logic ready [4];
  int   mode = 0;
  int   n_cmp = 0;
  int   n_mis = 0;
  exp_t sb [$];

  logic        busy_w  [4];
  logic        valid_w [4];
  logic [3:0]  vec_w   [4];
  logic [31:0] data_w  [4];
  logic [15:0] ones_w  [4];

  logic [15:0] d0, d1, d2;
  logic [31:0] d3;
  logic [4:0]  o0, o1, o2;
  logic [9:0]  o3;
  logic        f0, f1, f2;
  logic [1:0]  f3;

  int settle_of [4] = '{1, 0, 15, 1};

  always #5 clk = ~clk;

  // Netlist stand-ins driven from each instance's vector.
  assign f0 = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : ~(vec_w[0][1] ^ vec_w[0][3]);
  assign f1 = ~(vec_w[1][1] ^ vec_w[1][3]);
  assign f2 = ~(vec_w[2][1] ^ vec_w[2][3]);
  assign f3 = {vec_w[3][0] & vec_w[3][1], vec_w[3][2] | vec_w[3][3]};

  assign data_w[0] = {16'h0, d0};
  assign data_w[1] = {16'h0, d1};
  assign data_w[2] = {16'h0, d2};
  assign data_w[3] = d3;
  assign ones_w[0] = {11'h0, o0};
  assign ones_w[1] = {11'h0, o1};
  assign ones_w[2] = {11'h0, o2};
  assign ones_w[3] = {6'h0, o3};

  truth_table_sampler #(.N_IN(4), .N_OUT(1), .SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy_w[0]), .vec_o(vec_w[0]),
    .f_i(f0), .tt_valid(valid_w[0]), .tt_ready(ready[0]), .tt_data(d0), .ones_cnt(o0));

  truth_table_sampler #(.N_IN(4), .N_OUT(1), .SETTLE(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy_w[1]), .vec_o(vec_w[1]),
    .f_i(f1), .tt_valid(valid_w[1]), .tt_ready(ready[1]), .tt_data(d1), .ones_cnt(o1));

  truth_table_sampler #(.N_IN(4), .N_OUT(1), .SETTLE(15)) u_s15 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .busy(busy_w[2]), .vec_o(vec_w[2]),
    .f_i(f2), .tt_valid(valid_w[2]), .tt_ready(ready[2]), .tt_data(d2), .ones_cnt(o2));

  truth_table_sampler #(.N_IN(4), .N_OUT(2), .SETTLE(1)) u_n2 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .busy(busy_w[3]), .vec_o(vec_w[3]),
    .f_i(f3), .tt_valid(valid_w[3]), .tt_ready(ready[3]), .tt_data(d3), .ones_cnt(o3));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference truth tables computed from the loopback functions.
  function automatic exp_t model(input int idx, input int md);
    exp_t e;
    logic [3:0] x;
    logic b0, b1;
    e.tt   = '0;
    e.ones = '0;
    for (int v = 0; v < 16; v++) begin
      x = v[3:0];
      if (idx == 3) begin
        b0 = x[2] | x[3];
        b1 = x[0] & x[1];
        e.tt[v]      = b0;
        e.tt[16 + v] = b1;
        e.ones[4:0]  = e.ones[4:0] + 5'(b0);
        e.ones[9:5]  = e.ones[9:5] + 5'(b1);
      end else begin
        if (idx == 0 && md == 1)      b0 = 1'b0;
        else if (idx == 0 && md == 2) b0 = 1'b1;
        else                          b0 = ~(x[1] ^ x[3]);
        e.tt[v]     = b0;
        e.ones[4:0] = e.ones[4:0] + 5'(b0);
      end
    end
    return e;
  endfunction

  task automatic check_zero(input int idx);
    chk("rst_vec",   64'(vec_w[idx]),   64'h0);
    chk("rst_busy",  64'(busy_w[idx]),  64'h0);
    chk("rst_valid", 64'(valid_w[idx]), 64'h0);
    chk("rst_data",  64'(data_w[idx]),  64'h0);
    chk("rst_ones",  64'(ones_w[idx]),  64'h0);
  endtask

  task automatic run(input int idx, input int stall, input bit early);
    int cyc;
    int last_chg;
    int settle;
    logic [3:0]  pv;
    logic [31:0] held;
    exp_t e;
    settle = settle_of[idx];
    @(negedge clk);
    start[idx] = 1'b1;
    if (early) ready[idx] = 1'b1;
    sb.push_back(model(idx, mode));
    @(negedge clk);
    start[idx] = 1'b0;
    cyc = 0;
    last_chg = 0;
    chk("busy_after_start", 64'(busy_w[idx]), 64'h1);
    chk("vec_start", 64'(vec_w[idx]), 64'h0);
    pv = vec_w[idx];
    while (!valid_w[idx] && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (vec_w[idx] != pv) begin
        chk("vec_period", 64'(cyc - last_chg), 64'(settle + 2));
        chk("vec_step", 64'(vec_w[idx]), 64'(4'(pv + 4'd1)));
        last_chg = cyc;
        pv = vec_w[idx];
      end
    end
    chk("latency", 64'(cyc), 64'(16 * (settle + 2)));
    chk("vec_last", 64'(vec_w[idx]), 64'hF);
    held = data_w[idx];
    for (int s = 0; s < stall; s++) begin
      ready[idx] = 1'b0;
      start[idx] = (s == 5 || s == 6);
      @(negedge clk);
      chk("stall_valid", 64'(valid_w[idx]), 64'h1);
      chk("stall_busy",  64'(busy_w[idx]),  64'h1);
      chk("stall_data",  64'(data_w[idx]),  64'(held));
    end
    // Handshake with a coincident start, which must be ignored.
    ready[idx] = 1'b1;
    start[idx] = 1'b1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("tt_data",  64'(data_w[idx]), 64'(e.tt));
      chk("ones_cnt", 64'(ones_w[idx]), 64'(e.ones));
    end else begin
      chk("sb_empty", 64'(sb.size()), 64'h1);
    end
    @(negedge clk);
    ready[idx] = 1'b0;
    start[idx] = 1'b0;
    chk("post_valid", 64'(valid_w[idx]), 64'h0);
    chk("post_busy",  64'(busy_w[idx]),  64'h0);
    chk("post_vec",   64'(vec_w[idx]),   64'hF);
    @(negedge clk);
    chk("no_restart", 64'(busy_w[idx]), 64'h0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0;
      ready[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero(0);
    check_zero(3);
    rst_n = 1'b1;
    @(negedge clk);

    mode = 0; run(0, 20, 1'b0);
    mode = 1; run(0, 0, 1'b0);
    mode = 2; run(0, 0, 1'b0);
    mode = 0; run(3, 0, 1'b0);

    // Abort mid-run with an asynchronous reset, then rerun cleanly.
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    cyc = 0;
    while (vec_w[0] != 4'd7 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_vec7", 64'(vec_w[0]), 64'h7);
    #2 rst_n = 1'b0;
    #1 check_zero(0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 0, 1'b0);

    run(1, 0, 1'b1);
    run(2, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
